// File: rtl/override_monitor_pkg.sv
// override_monitor_pkg
//
// Shared types and default constants for the override monitor.
//
// Contents:
//   DEF_*        default parameter values for override_monitor
//   mon_state_t  interval-tracking FSM states (IDLE, CAND, ACTIVE)
//   mon_event_t  event record layout {start, len, and_flag} at the default
//                widths. override_monitor packs its FIFO entries in the same
//                field order, using its own parameterised widths.
//   ptr_bits()   address width helper for power-of-two FIFO depths

package override_monitor_pkg;

    localparam int DEF_WIDTH   = 1;
    localparam int DEF_TS_W    = 16;
    localparam int DEF_LEN_W   = 12;
    localparam int DEF_MIN_CYC = 2;
    localparam int DEF_DEPTH   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CAND   = 2'd1,
        ACTIVE = 2'd2
    } mon_state_t;

    typedef struct packed {
        logic [DEF_TS_W-1:0]  start;
        logic [DEF_LEN_W-1:0] len;
        logic                 and_flag;
    } mon_event_t;

    // Address bits needed to index a power-of-two FIFO. Never returns less
    // than 1, so the wrap bit above it stays meaningful for small FIFOs.
    function automatic int ptr_bits(input int depth);
        int n;
        n = $clog2(depth);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/mon_event_fifo.sv
// mon_event_fifo
//
// Generic synchronous FIFO with first-word fall-through output read
// directly from registered storage.
//
// Parameters:
//   DW     entry width
//   DEPTH  number of entries, power of two, at least 2
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; empties the FIFO and clears storage
//   push       write request
//   push_data  entry to write
//   full       all DEPTH entries occupied
//   pop        read request; the head advances when the FIFO is not empty
//   pop_data   current head entry (holds last value while empty)
//   empty      no entries stored
//
// A push while full is accepted only if a pop happens on the same cycle;
// otherwise it is silently ignored and the caller decides what that means.

module mon_event_fifo
    import override_monitor_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          full,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          empty
);

    localparam int AW = ptr_bits(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_pop;
    logic          do_push;

    // The extra top pointer bit distinguishes full from empty when the
    // address bits coincide.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // When full, the slot being written is the one being read out this
    // cycle; the read sees the old contents and the write lands at the edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage is cleared on reset so the outputs read as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/override_monitor.sv
// override_monitor
//
// Watches an observed net against its expected continuous-assignment value
// a|b. Runs of at least MIN_CYC consecutive mismatching samples are reported
// as override events {start timestamp, length} through a valid/ready FIFO.
//
// Optional feature macro: OVERRIDE_MONITOR_AND_CHECK_EN
//   defined   - each event also records whether obs equalled a&b on every
//               mismatching cycle of the interval (evt_and)
//   undefined - no tracking logic, evt_and is tied 0
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   a, b       operands of the monitored assignment (WIDTH bits)
//   obs        observed net value (WIDTH bits)
//   ovf_clr    clears the sticky overflow flag
//   active     an override is currently declared
//   evt_valid  event FIFO head is valid
//   evt_ready  consumer accepts the head
//   evt_start  timestamp of the first mismatching sample (TS_W bits)
//   evt_len    number of mismatching samples, saturating (LEN_W bits)
//   evt_and    override equalled a&b throughout (optional feature)
//   overflow   sticky: an event was dropped because the FIFO was full

module override_monitor
    import override_monitor_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TS_W    = DEF_TS_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int MIN_CYC = DEF_MIN_CYC,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] obs,
    input  logic             ovf_clr,
    output logic             active,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [TS_W-1:0]  evt_start,
    output logic [LEN_W-1:0] evt_len,
    output logic             evt_and,
    output logic             overflow
);

`ifdef OVERRIDE_MONITOR_AND_CHECK_EN
    localparam int ENTRY_W = TS_W + LEN_W + 1;
`else
    localparam int ENTRY_W = TS_W + LEN_W;
`endif

    // In CAND, the sample that brings the count to MIN_CYC promotes to ACTIVE.
    localparam logic [LEN_W-1:0] CAND_LAST = LEN_W'(MIN_CYC - 1);
    localparam logic [LEN_W-1:0] LEN_MAX   = {LEN_W{1'b1}};

    logic [TS_W-1:0]    ts;
    logic               mis_q;
    logic [TS_W-1:0]    mis_ts;

    mon_state_t         state;
    mon_state_t         state_n;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   cnt_n;
    logic [TS_W-1:0]    start;
    logic [TS_W-1:0]    start_n;
    logic               push;

    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop_ok;
    logic               drop;
    logic               ovf;

`ifdef OVERRIDE_MONITOR_AND_CHECK_EN
    logic               and_q;
    logic               and_ok;
    logic               and_ok_n;
`endif

    // Free-running timestamp plus the registered mismatch sample. The
    // timestamp of each sample travels with it so the FSM, one cycle later,
    // captures the time the mismatch was actually seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts     <= '0;
            mis_q  <= 1'b0;
            mis_ts <= '0;
        end else begin
            ts     <= ts + 1'b1;
            mis_q  <= (obs != (a | b));
            mis_ts <= ts;
        end
    end

`ifdef OVERRIDE_MONITOR_AND_CHECK_EN
    // Registered alongside mis_q so both describe the same sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            and_q <= 1'b0;
        end else begin
            and_q <= (obs == (a & b));
        end
    end
`endif

    // Interval FSM state and per-interval capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            start <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            start <= start_n;
        end
    end

`ifdef OVERRIDE_MONITOR_AND_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            and_ok <= 1'b0;
        end else begin
            and_ok <= and_ok_n;
        end
    end
`endif

    // Next-state logic. cnt always holds the number of mismatching samples
    // seen in the current interval. The matching sample that closes an
    // ACTIVE interval returns to IDLE without starting a new one, so back to
    // back intervals are always separated by at least one matching sample.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        start_n  = start;
        push     = 1'b0;
`ifdef OVERRIDE_MONITOR_AND_CHECK_EN
        and_ok_n = and_ok;
`endif
        case (state)
            IDLE: begin
                if (mis_q) begin
                    start_n  = mis_ts;
                    cnt_n    = LEN_W'(1);
`ifdef OVERRIDE_MONITOR_AND_CHECK_EN
                    and_ok_n = and_q;
`endif
                    state_n  = (MIN_CYC == 1) ? ACTIVE : CAND;
                end
            end
            CAND: begin
                if (mis_q) begin
                    cnt_n    = cnt + 1'b1;
`ifdef OVERRIDE_MONITOR_AND_CHECK_EN
                    and_ok_n = and_ok & and_q;
`endif
                    if (cnt == CAND_LAST) begin
                        state_n = ACTIVE;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            ACTIVE: begin
                if (mis_q) begin
                    if (cnt != LEN_MAX) begin
                        cnt_n = cnt + 1'b1;
                    end
`ifdef OVERRIDE_MONITOR_AND_CHECK_EN
                    and_ok_n = and_ok & and_q;
`endif
                end else begin
                    push    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign active = (state == ACTIVE);

`ifdef OVERRIDE_MONITOR_AND_CHECK_EN
    assign fifo_din = {start, cnt, and_ok};
`else
    assign fifo_din = {start, cnt};
`endif

    mon_event_fifo #(
        .DW    (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_din),
        .full      (fifo_full),
        .pop       (evt_ready),
        .pop_data  (fifo_dout),
        .empty     (fifo_empty)
    );

    // A push into a full FIFO is only lost when no pop frees a slot on the
    // same cycle; the FIFO itself accepts the simultaneous case.
    assign pop_ok = evt_ready && !fifo_empty;
    assign drop   = push && fifo_full && !pop_ok;

    // Sticky overflow: a drop takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    assign overflow  = ovf;
    assign evt_valid = !fifo_empty;

`ifdef OVERRIDE_MONITOR_AND_CHECK_EN
    assign {evt_start, evt_len, evt_and} = fifo_dout;
`else
    assign {evt_start, evt_len} = fifo_dout;
    assign evt_and              = 1'b0;
`endif

endmodule

// File: tb/tb_override_monitor.sv
// tb_override_monitor
//
// Self-checking bench for override_monitor with default parameters.
// The reference model tracks runs of mismatching samples and an event queue
// directly, rather than any state machine. Inputs change and outputs are
// observed on the falling edge.

module tb_override_monitor;

    localparam int TS_W    = 16;
    localparam int LEN_W   = 12;
    localparam int MIN_CYC = 2;
    localparam int DEPTH   = 8;
    localparam int LEN_SAT = (1 << LEN_W) - 1;

`ifdef OVERRIDE_MONITOR_AND_CHECK_EN
    localparam bit AND_EN = 1'b1;
`else
    localparam bit AND_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_s = 1'b1;
    logic             b_s = 1'b0;
    logic             obs_s = 1'b1;
    logic             ovf_clr_s = 1'b0;
    logic             evt_ready_s = 1'b0;
    logic             active;
    logic             evt_valid;
    logic [TS_W-1:0]  evt_start;
    logic [LEN_W-1:0] evt_len;
    logic             evt_and;
    logic             overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int start;
        int len;
        bit andf;
    } mevt_t;

    mevt_t mq[$];
    mevt_t pend;
    bit    pend_valid = 1'b0;
    int    run_len    = 0;
    int    run_start  = 0;
    bit    run_and    = 1'b0;
    bit    m_ovf      = 1'b0;
    bit    m_active   = 1'b0;
    int    m_ts       = 0;

    override_monitor #(
        .WIDTH   (1),
        .TS_W    (TS_W),
        .LEN_W   (LEN_W),
        .MIN_CYC (MIN_CYC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a_s),
        .b         (b_s),
        .obs       (obs_s),
        .ovf_clr   (ovf_clr_s),
        .active    (active),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready_s),
        .evt_start (evt_start),
        .evt_len   (evt_len),
        .evt_and   (evt_and),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model, advanced once per rising edge using the inputs that
    // were stable across that edge. Events are runs of >= MIN_CYC mismatching
    // samples; a run is reported on the edge after its first matching sample.
    function automatic void model_step();
        mevt_t e;
        bit    drop;
        bit    mm;
        if (rst) begin
            mq.delete();
            pend_valid = 1'b0;
            run_len    = 0;
            m_ovf      = 1'b0;
            m_active   = 1'b0;
            m_ts       = 0;
            return;
        end
        if (mq.size() != 0 && evt_ready_s) begin
            e = mq.pop_front();
        end
        drop = 1'b0;
        if (pend_valid) begin
            if (mq.size() < DEPTH) mq.push_back(pend);
            else drop = 1'b1;
        end
        pend_valid = 1'b0;
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr_s) m_ovf = 1'b0;
        m_active = (run_len >= MIN_CYC);
        mm = (obs_s != (a_s | b_s));
        if (mm) begin
            if (run_len == 0) begin
                run_start = m_ts;
                run_and   = 1'b1;
            end
            run_len++;
            if (obs_s != (a_s & b_s)) run_and = 1'b0;
        end else begin
            if (run_len >= MIN_CYC) begin
                pend.start = run_start;
                pend.len   = (run_len > LEN_SAT) ? LEN_SAT : run_len;
                pend.andf  = AND_EN ? run_and : 1'b0;
                pend_valid = 1'b1;
            end
            run_len = 0;
        end
        m_ts = (m_ts + 1) % (1 << TS_W);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // One sample with a=1,b=0: obs=0 is a mismatch equal to a&b, obs=1 matches.
    task automatic drive_sample(input bit mis, input bit rdy, input bit clr);
        a_s         = 1'b1;
        b_s         = 1'b0;
        obs_s       = mis ? 1'b0 : 1'b1;
        evt_ready_s = rdy;
        ovf_clr_s   = clr;
        tick();
    endtask

    task automatic do_reset(input int n);
        rst         = 1'b1;
        a_s         = 1'b1;
        b_s         = 1'b0;
        obs_s       = 1'b1;
        evt_ready_s = 1'b0;
        ovf_clr_s   = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3);
        total++; if (active !== 1'b0) begin bad++; $display("[TB] FAIL reset_active got=%b exp=0", active); end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", evt_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (evt_start !== '0 || evt_len !== '0 || evt_and !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_evt got start=%0d len=%0d and=%b exp 0", evt_start, evt_len, evt_and);
        end
        for (int n = 0; n < 20; n++) begin
            drive_sample(1'b0, 1'b0, 1'b0);
            total++;
            if (active !== 1'b0 || evt_valid !== 1'b0 || overflow !== 1'b0) begin
                bad++;
                $display("[TB] FAIL idle_match n=%0d got act=%b vld=%b ovf=%b exp 0", n, active, evt_valid, overflow);
            end
        end
    endtask

    task automatic test_long_override();
        do_reset(3);
        for (int n = 0; n < 96; n++) begin
            drive_sample(n >= 10 && n < 90, 1'b1, 1'b0);
            total++;
            if (active !== m_active) begin
                bad++; $display("[TB] FAIL long_active_model n=%0d got=%b exp=%b", n, active, m_active);
            end
            if (n == 11) begin
                total++; if (active !== 1'b0) begin bad++; $display("[TB] FAIL long_active_e11 got=%b exp=0", active); end
            end
            if (n == 12) begin
                total++; if (active !== 1'b1) begin bad++; $display("[TB] FAIL long_active_e12 got=%b exp=1", active); end
            end
            if (n == 91) begin
                total++;
                if (evt_valid !== 1'b1 || evt_start !== 16'd10 || evt_len !== 12'd80 || evt_and !== AND_EN) begin
                    bad++;
                    $display("[TB] FAIL long_event got vld=%b start=%0d len=%0d and=%b exp vld=1 start=10 len=80 and=%b",
                             evt_valid, evt_start, evt_len, evt_and, AND_EN);
                end
            end
            if (n == 92) begin
                total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL long_drained got=%b exp=0", evt_valid); end
            end
        end
    endtask

    task automatic test_glitch();
        do_reset(2);
        for (int n = 0; n < 16; n++) begin
            drive_sample(n == 5, 1'b0, 1'b0);
            total++;
            if (active !== 1'b0 || evt_valid !== 1'b0) begin
                bad++; $display("[TB] FAIL glitch n=%0d got act=%b vld=%b exp 0 0", n, active, evt_valid);
            end
        end
    endtask

    // Overrides i=0..count-1 occupy samples 2+5i .. 4+5i.
    function automatic bit pattern_mis(input int n, input int count);
        return (n >= 2) && (((n - 2) % 5) < 3) && (((n - 2) / 5) < count);
    endfunction

    task automatic test_overflow();
        do_reset(2);
        for (int n = 0; n < 50; n++) drive_sample(pattern_mis(n, 9), 1'b0, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set got=%b exp=1", overflow); end
        total++; if (mq.size() != DEPTH) begin bad++; $display("[TB] FAIL ovf_model_depth got=%0d exp=%0d", mq.size(), DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (evt_valid !== 1'b1 || evt_start !== 16'(2 + 5 * i) || evt_len !== 12'd3) begin
                bad++;
                $display("[TB] FAIL ovf_drain i=%0d got vld=%b start=%0d len=%0d exp vld=1 start=%0d len=3",
                         i, evt_valid, evt_start, evt_len, 2 + 5 * i);
            end
            drive_sample(1'b0, 1'b1, 1'b0);
        end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovf_empty got=%b exp=0", evt_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky got=%b exp=1", overflow); end
        drive_sample(1'b0, 1'b0, 1'b1);
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_back_to_back_full();
        do_reset(2);
        // The 9th event is pushed at edge 46, the only edge with ready high.
        for (int n = 0; n < 50; n++) drive_sample(pattern_mis(n, 9), n == 46, 1'b0);
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL full_pp_ovf got=%b exp=0", overflow); end
        for (int i = 1; i <= DEPTH; i++) begin
            total++;
            if (evt_valid !== 1'b1 || evt_start !== 16'(2 + 5 * i) || evt_len !== 12'd3) begin
                bad++;
                $display("[TB] FAIL full_pp_drain i=%0d got vld=%b start=%0d len=%0d exp vld=1 start=%0d len=3",
                         i, evt_valid, evt_start, evt_len, 2 + 5 * i);
            end
            drive_sample(1'b0, 1'b1, 1'b0);
        end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_pp_empty got=%b exp=0", evt_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        for (int n = 0; n < 13; n++) drive_sample((n >= 3 && n <= 5) || n >= 8, 1'b0, 1'b0);
        total++; if (active !== 1'b1 || evt_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL rstmid_pre got act=%b vld=%b exp 1 1", active, evt_valid);
        end
        rst = 1'b1;
        tick();
        total++;
        if (active !== 1'b0 || evt_valid !== 1'b0 || overflow !== 1'b0 || evt_start !== '0 || evt_len !== '0 || evt_and !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_zero got act=%b vld=%b ovf=%b start=%0d len=%0d and=%b exp all 0",
                     active, evt_valid, overflow, evt_start, evt_len, evt_and);
        end
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            drive_sample(1'b0, 1'b0, 1'b0);
            total++;
            if (evt_valid !== 1'b0 || active !== 1'b0) begin
                bad++; $display("[TB] FAIL rstmid_after n=%0d got vld=%b act=%b exp 0 0", n, evt_valid, active);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset(2);
        for (int n = 0; n < 4103; n++) drive_sample(n >= 1 && n <= 4100, 1'b0, 1'b0);
        total++;
        if (evt_valid !== 1'b1 || evt_start !== 16'd1 || evt_len !== 12'(LEN_SAT)) begin
            bad++;
            $display("[TB] FAIL sat_event got vld=%b start=%0d len=%0d exp vld=1 start=1 len=%0d",
                     evt_valid, evt_start, evt_len, LEN_SAT);
        end
    endtask

    task automatic test_random();
        int burst;
        do_reset(2);
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            if (burst == 0 && $urandom_range(0, 99) < 15) burst = $urandom_range(1, 6);
            a_s = 1'($urandom);
            b_s = 1'($urandom);
            if (burst > 0) begin
                obs_s = ~(a_s | b_s);
                burst--;
            end else begin
                obs_s = a_s | b_s;
            end
            evt_ready_s = ($urandom_range(0, 99) < 35);
            ovf_clr_s   = ($urandom_range(0, 99) < 3);
            tick();
            total++;
            if (active !== m_active || evt_valid !== (mq.size() != 0) || overflow !== m_ovf) begin
                bad++;
                $display("[TB] FAIL rand_ctrl n=%0d got act=%b vld=%b ovf=%b exp act=%b vld=%b ovf=%b",
                         n, active, evt_valid, overflow, m_active, mq.size() != 0, m_ovf);
            end
            if (mq.size() != 0) begin
                total++;
                if (evt_start !== 16'(mq[0].start) || evt_len !== 12'(mq[0].len) || evt_and !== mq[0].andf) begin
                    bad++;
                    $display("[TB] FAIL rand_head n=%0d got start=%0d len=%0d and=%b exp start=%0d len=%0d and=%b",
                             n, evt_start, evt_len, evt_and, mq[0].start, mq[0].len, mq[0].andf);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        $display("[TB] test_reset");
        test_reset();
        $display("[TB] test_long_override");
        test_long_override();
        $display("[TB] test_glitch");
        test_glitch();
        $display("[TB] test_overflow");
        test_overflow();
        $display("[TB] test_back_to_back_full");
        test_back_to_back_full();
        $display("[TB] test_reset_mid");
        test_reset_mid();
        $display("[TB] test_saturation");
        test_saturation();
        $display("[TB] test_random");
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/override_monitor.md
Name: override_monitor

Overview:
- Checker-side counterpart to net override stimulus: watches an observed net against its expected continuous-assignment value `a|b`.
- Detects intervals where the net is overridden (value differs from expected) and timestamps each interval.
- Queues completed override events in an internal FIFO, drained over a valid/ready port.
- Sits beside DUT nets in self-checking benches and FPGA debug builds.

Parameters:
- WIDTH, 1, width of a, b, obs.
- TS_W, 16, free-running timestamp width.
- LEN_W, 12, duration field width.
- MIN_CYC, 2, consecutive mismatch cycles needed to declare an override (≥1).
- DEPTH, 8, event FIFO entries (power of 2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- a  in  WIDTH  operand a of monitored assignment.
- b  in  WIDTH  operand b of monitored assignment.
- obs  in  WIDTH  observed net value.
- ovf_clr  in  1  clears sticky overflow.
- active  out  1  override currently declared.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts head.
- evt_start  out  TS_W  timestamp of first mismatching cycle.
- evt_len  out  LEN_W  mismatching cycle count, saturating.
- evt_and  out  1  override matched `a&b` on every cycle (see Optional Feature).
- overflow  out  1  sticky: an event was dropped.

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; timestamp 0.
- Timestamp `ts` increments every cycle and wraps modulo 2^TS_W.
- Mismatch is registered: `mis = (obs != (a|b))`, sampled each clock. Compare is full-width; any bit differing counts.
- FSM states:
  - IDLE: on mis, capture start=ts, cnt=1. If MIN_CYC==1 go to ACTIVE, else go to CAND.
  - CAND: mis and cnt+1==MIN_CYC → ACTIVE; mis otherwise → cnt++; !mis → IDLE with no event (glitch filtered).
  - ACTIVE: `active`=1. mis → cnt++, saturating at 2^LEN_W−1. !mis → push {start, cnt}, go to IDLE.
  - The !mis cycle that ends ACTIVE is never also the start of a new interval. A new interval needs mis on a later cycle.
- Latency: `active` rises at clock edge MIN_CYC after the first mismatching sample. An event is visible on evt_valid one cycle after the ending sample.
- FIFO handshake:
  - Transfer occurs when evt_valid && evt_ready.
  - evt_* are stable while valid and not ready.
  - Output is first-word fall-through from registered storage.
- Full:
  - Push while full with no pop → event dropped, overflow=1.
  - Simultaneous pop and push when full → both succeed, no overflow.
- Empty: evt_valid=0; evt_* hold last value, don't care.
- overflow clears only on ovf_clr or rst. If ovf_clr coincides with a drop, set wins.
- Reset mid-override: in-progress interval discarded; no event emitted.

Optional Feature:
- Macro: OVERRIDE_MONITOR_AND_CHECK_EN.
- Defined:
  - Tracks `and_ok &= (obs == (a&b))` across the interval; and_ok is cleared per interval.
  - Latched into the event as evt_and.
- Undefined:
  - No tracking logic.
  - evt_and tied 0; FIFO entry excludes the bit.

Decomposition:
- Package override_monitor_pkg:
  - FSM state enum {IDLE, CAND, ACTIVE}.
  - Event struct {start, len, and_flag}, parameterised via localparams.
  - Default width constants.
- Sub-module mon_event_fifo:
  - Generic DEPTH×width synchronous FIFO with push/full/pop/empty.
  - Simultaneous-push-pop-when-full handled internally.

Test Plan:
- Reset hold 3 cycles, then `a=1,b=0,obs=1` for 20 cycles → active=0, evt_valid=0, overflow=0.
- Sample 10: obs forced to `a&b` (differs, a=1,b=0 → obs=0), released at sample 90, evt_ready=1:
  - active rises at edge 12.
  - One event: start=10, len=80, evt_and=1 with macro, 0 without.
- Single-cycle mismatch with MIN_CYC=2 → no event, active never asserts.
- Hold evt_ready=0, create 9 overrides of 3 cycles each (DEPTH=8):
  - 8 events queued, overflow=1.
  - Draining yields 8 events in order with correct starts.
- FIFO full, evt_ready=1 on the cycle an override ends → event accepted, overflow stays 0.
- rst asserted 5 cycles into an override:
  - All outputs 0 next cycle.
  - After release with obs matching, no event appears.
